gold_nic: RTL and testbench

Network interface controller between one processor core and one node of the cardinal bidirectional ring. Toward the core it exposes a four-address register window: input buffer, input status, output buffer, output status. Toward the ring node it drives the node's pesi/pedi pair and accepts its peso/pedo pair. Each direction uses a one-deep channel buffer, and packets are injected only in the clock phase matching their virtual-channel bit.

---
 rtl/gold_ring_pkg.sv | 13 +
 rtl/nic_channel_buf.sv | 29 ++
 rtl/gold_nic.sv | 73 +++++++
 tb/tb_gold_nic.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/gold_ring_pkg.sv
// gold_ring_pkg: packet field positions and NIC register addresses shared by the ring NIC
package gold_ring_pkg;
  localparam int VC_BIT = 63;
  localparam int DIR_BIT = 62;
  localparam int HOP_MSB = 55;
  localparam int HOP_LSB = 48;
  localparam int SRC_MSB = 47;
  localparam int SRC_LSB = 32;
  localparam logic [1:0] ADDR_IN_BUF = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT = 2'b01;
  localparam logic [1:0] ADDR_OUT_BUF = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;
endpackage

// File: rtl/nic_channel_buf.sv
// nic_channel_buf: one-deep packet buffer with load/unload strobes and a full flag
module nic_channel_buf #(
  parameter int W = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_unload,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full
);
  logic [W-1:0] r_data;
  logic         r_full;
  // Data is kept after unload so a read of an empty buffer returns the stale packet
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else if (i_load) begin
      r_data <= i_data;
      r_full <= 1'b1;
    end else if (i_unload) begin
      r_full <= 1'b0;
    end
  end
  assign o_data = r_data;
  assign o_full = r_full;
endmodule

// File: rtl/gold_nic.sv
// gold_nic: core-facing register window bridging one processor to a ring node,
// with one-deep buffers per direction and polarity-gated injection
module gold_nic
  import gold_ring_pkg::*;
#(
  parameter int PAC_SIZE = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          addr,
  input  logic [PAC_SIZE-1:0] d_in,
  output logic [PAC_SIZE-1:0] d_out,
  input  logic                nicEn,
  input  logic                nicWrEn,
  input  logic                net_si,
  output logic                net_ro,
  input  logic [PAC_SIZE-1:0] net_di,
  output logic                net_so,
  input  logic                net_ri,
  output logic [PAC_SIZE-1:0] net_do,
  input  logic                net_polarity
);
  logic [PAC_SIZE-1:0] r_d_out;
  logic                r_drop_err;
  logic [PAC_SIZE-1:0] w_in_data;
  logic [PAC_SIZE-1:0] w_out_data;
  logic [PAC_SIZE-1:0] w_rd_data;
  logic                w_in_full;
  logic                w_out_full;
  logic                w_rd;
  logic                w_wr;
  logic                w_in_load;
  logic                w_in_unload;
  logic                w_out_load;
  logic                w_drop;
  logic                w_clr_err;
  assign w_rd        = nicEn & ~nicWrEn;
  assign w_wr        = nicEn & nicWrEn;
  assign net_ro      = ~w_in_full;
  assign w_in_load   = net_si & net_ro;
  assign w_in_unload = w_rd & (addr == ADDR_IN_BUF) & w_in_full;
  assign w_out_load  = w_wr & (addr == ADDR_OUT_BUF) & ~w_out_full;
  // A write colliding with an injection edge still sees out_full = 1 and is dropped
  assign w_drop      = w_wr & (addr == ADDR_OUT_BUF) & w_out_full;
  assign w_clr_err   = w_wr & (addr == ADDR_OUT_STAT) & d_in[1];
  assign net_so      = w_out_full & net_ri & (w_out_data[VC_BIT] == net_polarity);
  assign net_do      = w_out_data;
  assign d_out       = r_d_out;
  always_comb begin
    w_rd_data = (addr == ADDR_IN_BUF)   ? w_in_data :
                (addr == ADDR_IN_STAT)  ? {{(PAC_SIZE-1){1'b0}}, w_in_full} :
                (addr == ADDR_OUT_STAT) ? {{(PAC_SIZE-2){1'b0}}, r_drop_err, w_out_full} :
                '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_d_out    <= '0;
      r_drop_err <= 1'b0;
    end else begin
      if (w_rd) r_d_out <= w_rd_data;
      if (w_drop) r_drop_err <= 1'b1;
      else if (w_clr_err) r_drop_err <= 1'b0;
    end
  end
  nic_channel_buf #(.W(PAC_SIZE)) u_in (
    .i_clk(clk), .i_rst(reset), .i_load(w_in_load), .i_unload(w_in_unload),
    .i_data(net_di), .o_data(w_in_data), .o_full(w_in_full)
  );
  nic_channel_buf #(.W(PAC_SIZE)) u_out (
    .i_clk(clk), .i_rst(reset), .i_load(w_out_load), .i_unload(net_so),
    .i_data(d_in), .o_data(w_out_data), .o_full(w_out_full)
  );
endmodule

// File: tb/tb_gold_nic.sv
// tb_gold_nic: directed self-checking bench for the gold_nic register window and ring handshake
module tb_gold_nic;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  addr = 2'b00;
  logic [63:0] d_in = '0;
  logic [63:0] d_out;
  logic        nicEn = 1'b0;
  logic        nicWrEn = 1'b0;
  logic        net_si = 1'b0;
  logic        net_ro;
  logic [63:0] net_di = '0;
  logic        net_so;
  logic        net_ri = 1'b0;
  logic [63:0] net_do;
  logic        net_polarity = 1'b0;
  int checks = 0;
  int errors = 0;

  gold_nic #(.PAC_SIZE(64)) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_ro(net_ro),
    .net_di(net_di), .net_so(net_so), .net_ri(net_ri), .net_do(net_do),
    .net_polarity(net_polarity)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [63:0] v);
    addr = a; nicEn = 1'b1; nicWrEn = 1'b0;
    tick();
    nicEn = 1'b0;
    v = d_out;
  endtask

  task automatic wr(input logic [1:0] a, input logic [63:0] v);
    addr = a; d_in = v; nicEn = 1'b1; nicWrEn = 1'b1;
    tick();
    nicEn = 1'b0; nicWrEn = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] v;
    #3 reset = 1'b1;
    #1;
    checks++; if (net_ro !== 1'b1) begin errors++; $display("FAIL reset_net_ro got %b want 1", net_ro); end
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL reset_net_so got %b want 0", net_so); end
    checks++; if (d_out !== 64'd0) begin errors++; $display("FAIL reset_d_out got %h want 0", d_out); end
    checks++; if (net_do !== 64'd0) begin errors++; $display("FAIL reset_net_do got %h want 0", net_do); end
    tick();
    reset = 1'b0;
    rd(2'b01, v);
    checks++; if (v !== 64'd0) begin errors++; $display("FAIL reset_in_stat got %h want 0", v); end
    rd(2'b11, v);
    checks++; if (v !== 64'd0) begin errors++; $display("FAIL reset_out_stat got %h want 0", v); end
  endtask

  task automatic test_receive();
    logic [63:0] v;
    net_si = 1'b1; net_di = 64'h0000_0001_DEAD_BEEF;
    tick();
    net_si = 1'b0; net_di = '0;
    checks++; if (net_ro !== 1'b0) begin errors++; $display("FAIL rx_ro_low got %b want 0", net_ro); end
    rd(2'b01, v);
    checks++; if (v !== 64'd1) begin errors++; $display("FAIL rx_in_stat got %h want 1", v); end
    rd(2'b00, v);
    checks++; if (v !== 64'h0000_0001_DEAD_BEEF) begin errors++; $display("FAIL rx_data got %h want 0000_0001_DEAD_BEEF", v); end
    checks++; if (net_ro !== 1'b1) begin errors++; $display("FAIL rx_ro_high got %b want 1", net_ro); end
    rd(2'b00, v);
    checks++; if (v !== 64'h0000_0001_DEAD_BEEF) begin errors++; $display("FAIL rx_stale got %h want 0000_0001_DEAD_BEEF", v); end
    rd(2'b01, v);
    checks++; if (v !== 64'd0) begin errors++; $display("FAIL rx_empty_stat got %h want 0", v); end
    rd(2'b10, v);
    checks++; if (v !== 64'd0) begin errors++; $display("FAIL rd_out_buf got %h want 0", v); end
  endtask

  task automatic test_inject();
    logic [63:0] v;
    net_ri = 1'b1; net_polarity = 1'b0;
    wr(2'b10, 64'h8000_0000_0000_00AA);
    #1;
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL vc1_wrong_phase got %b want 0", net_so); end
    checks++; if (net_do !== 64'h8000_0000_0000_00AA) begin errors++; $display("FAIL vc1_net_do got %h want 8000_0000_0000_00AA", net_do); end
    net_polarity = 1'b1;
    #1;
    checks++; if (net_so !== 1'b1) begin errors++; $display("FAIL vc1_right_phase got %b want 1", net_so); end
    tick();
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL vc1_after got %b want 0", net_so); end
    net_polarity = 1'b1;
    wr(2'b10, 64'h0000_0000_0000_0055);
    #1;
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL vc0_wrong_phase got %b want 0", net_so); end
    net_polarity = 1'b0;
    #1;
    checks++; if (net_so !== 1'b1) begin errors++; $display("FAIL vc0_right_phase got %b want 1", net_so); end
    tick();
    rd(2'b11, v);
    checks++; if (v !== 64'd0) begin errors++; $display("FAIL vc0_out_stat got %h want 0", v); end
  endtask

  task automatic test_backpressure();
    logic [63:0] v;
    logic seen;
    net_ri = 1'b0; net_polarity = 1'b0;
    wr(2'b10, 64'h0000_0000_0000_0123);
    for (int i = 0; i < 10; i++) begin
      net_polarity = ~net_polarity;
      #1;
      checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL bp_so cycle %0d got %b want 0", i, net_so); end
      checks++; if (net_do !== 64'h0000_0000_0000_0123) begin errors++; $display("FAIL bp_do cycle %0d got %h want 123", i, net_do); end
      tick();
    end
    net_ri = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 2 && !seen; i++) begin
      net_polarity = ~net_polarity;
      #1;
      if (net_so) seen = 1'b1;
      tick();
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL bp_release got %b want 1", seen); end
    rd(2'b11, v);
    checks++; if (v !== 64'd0) begin errors++; $display("FAIL bp_out_stat got %h want 0", v); end
  endtask

  task automatic test_overflow();
    logic [63:0] v;
    net_ri = 1'b0;
    wr(2'b10, 64'h8000_0000_0000_0001);
    wr(2'b10, 64'h0000_0000_0000_0002);
    checks++; if (net_do !== 64'h8000_0000_0000_0001) begin errors++; $display("FAIL ovf_kept got %h want 8000_0000_0000_0001", net_do); end
    rd(2'b11, v);
    checks++; if (v !== 64'd3) begin errors++; $display("FAIL ovf_stat got %h want 3", v); end
    wr(2'b11, 64'd2);
    rd(2'b11, v);
    checks++; if (v !== 64'd1) begin errors++; $display("FAIL ovf_clear got %h want 1", v); end
    net_ri = 1'b1; net_polarity = 1'b1;
    tick();
    rd(2'b11, v);
    checks++; if (v !== 64'd0) begin errors++; $display("FAIL ovf_drain got %h want 0", v); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] v;
    net_ri = 1'b0;
    wr(2'b10, 64'h8000_0000_0000_0AAA);
    net_ri = 1'b1; net_polarity = 1'b1;
    wr(2'b10, 64'h0000_0000_0000_0BBB);
    checks++; if (net_do !== 64'h8000_0000_0000_0AAA) begin errors++; $display("FAIL col_do got %h want 8000_0000_0000_0AAA", net_do); end
    rd(2'b11, v);
    checks++; if (v !== 64'd2) begin errors++; $display("FAIL col_stat got %h want 2", v); end
    wr(2'b11, 64'd2);
    rd(2'b11, v);
    checks++; if (v !== 64'd0) begin errors++; $display("FAIL col_clear got %h want 0", v); end
  endtask

  task automatic test_reset_mid_transfer();
    net_ri = 1'b0;
    net_si = 1'b1; net_di = 64'h1234_5678_9ABC_DEF0;
    tick();
    net_si = 1'b0;
    wr(2'b10, 64'h8000_0000_0000_0777);
    addr = 2'b01; nicEn = 1'b1;
    tick();
    nicEn = 1'b0;
    net_ri = 1'b1; net_polarity = 1'b1;
    #2 reset = 1'b1;
    #1;
    checks++; if (net_ro !== 1'b1) begin errors++; $display("FAIL rst_mid_ro got %b want 1", net_ro); end
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL rst_mid_so got %b want 0", net_so); end
    checks++; if (net_do !== 64'd0) begin errors++; $display("FAIL rst_mid_do got %h want 0", net_do); end
    checks++; if (d_out !== 64'd0) begin errors++; $display("FAIL rst_mid_d_out got %h want 0", d_out); end
    tick();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_receive();
    test_inject();
    test_backpressure();
    test_overflow();
    test_back_to_back();
    test_reset_mid_transfer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
